// File: rtl/tick_generator_multi.sv
// Multi-channel tick / clock-enable generator: each channel divides clock_in by a
// runtime-reloadable divisor and produces a one-cycle tick plus a square wave.
module tick_generator_multi #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 26,
  parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV = {26'd5_000_000, 26'd50_000_000,
                                                 26'd25_000_000, 26'd500_000},
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              sync_clr,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [DIV_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] square
);

  // Divisors below 2 cannot produce a square wave, so they are clamped.
  logic [DIV_W-1:0] wr_val;
  assign wr_val = (div_data < DIV_W'(2)) ? DIV_W'(2) : div_data;

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             tick_q, tick_d;
    logic             square_q, square_d;
    logic             wrap;
    logic             hit;
    logic [DIV_W-1:0] cnt_inc;

    // Wrap uses >= so a divisor shrunk below the held count while disabled
    // still ends the period on the next enabled edge instead of running away.
    assign wrap    = (cnt_q >= (act_q - DIV_W'(1)));
    assign cnt_inc = wrap ? '0 : (cnt_q + DIV_W'(1));
    assign hit     = div_wr && (div_sel == SEL_W'(i));

    always_comb begin
      cnt_d      = cnt_q;
      act_d      = act_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      tick_d     = 1'b0;
      square_d   = square_q;
      if (sync_clr) begin
        cnt_d      = '0;
        square_d   = 1'b0;
        pend_vld_d = 1'b0;
        if (hit) begin
          act_d = wr_val;
        end else if (pend_vld_q) begin
          act_d = pend_q;
        end
      end else if (ch_enable[i]) begin
        cnt_d    = cnt_inc;
        tick_d   = wrap;
        square_d = (cnt_inc >= (act_q >> 1));
        if (wrap) begin
          if (hit) begin
            act_d      = wr_val;
            pend_vld_d = 1'b0;
          end else if (pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = 1'b0;
          end
        end else if (hit) begin
          pend_d     = wr_val;
          pend_vld_d = 1'b1;
        end
      end else if (hit) begin
        act_d      = wr_val;
        pend_vld_d = 1'b0;
      end
    end

    always_ff @(posedge clock_in) begin
      if (!reset_n) begin
        cnt_q      <= '0;
        act_q      <= DEF_DIV[i*DIV_W +: DIV_W];
        pend_q     <= '0;
        pend_vld_q <= 1'b0;
        tick_q     <= 1'b0;
        square_q   <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        act_q      <= act_d;
        pend_q     <= pend_d;
        pend_vld_q <= pend_vld_d;
        tick_q     <= tick_d;
        square_q   <= square_d;
      end
    end

    assign tick[i]   = tick_q;
    assign square[i] = square_q;
  end

endmodule

// File: tb/tb_tick_generator_multi.sv
// Bench for tick_generator_multi: a 4-channel instance plus a 3-channel instance
// that exposes an out-of-range div_sel, both checked against a scoreboard model.
module tb_tick_generator_multi;

  logic       clock_in;
  logic       reset_n;
  logic [3:0] ch_enable;
  logic       sync_clr;
  logic       div_wr;
  logic [1:0] div_sel;
  logic [7:0] div_data;
  logic [3:0] tick, square;
  logic [2:0] tick3, square3;

  tick_generator_multi #(.NUM_CH(4), .DIV_W(8),
                         .DEF_DIV({8'd10, 8'd2, 8'd5, 8'd4})) dut (
    .clock_in(clock_in), .reset_n(reset_n), .ch_enable(ch_enable),
    .sync_clr(sync_clr), .div_wr(div_wr), .div_sel(div_sel),
    .div_data(div_data), .tick(tick), .square(square));

  tick_generator_multi #(.NUM_CH(3), .DIV_W(8),
                         .DEF_DIV({8'd2, 8'd5, 8'd4})) dut3 (
    .clock_in(clock_in), .reset_n(reset_n), .ch_enable(ch_enable[2:0]),
    .sync_clr(sync_clr), .div_wr(div_wr), .div_sel(div_sel),
    .div_data(div_data), .tick(tick3), .square(square3));

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  typedef struct packed {
    logic [3:0] tick;
    logic [3:0] sq;
    logic [2:0] tick3;
    logic [2:0] sq3;
  } exp_t;

  typedef struct {
    logic [3:0] en;
    logic [3:0] exp_tick;
    logic [3:0] exp_sq;
  } vec_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model channels 0..3 belong to dut, 4..6 to dut3 (local index k-4).
  int def_div[4] = '{4, 5, 2, 10};
  int m_cnt[7], m_act[7], m_pend[7];
  bit m_pv[7], m_tick[7], m_sq[7];

  function automatic void modelStep(input logic rst_n, input logic [3:0] en,
                                    input logic sclr, input logic wr,
                                    input logic [1:0] sel, input logic [7:0] data);
    for (int k = 0; k < 7; k++) begin
      int idx;
      int wv;
      int nxt;
      bit hit;
      bit wrap;
      idx = (k < 4) ? k : k - 4;
      hit = wr && (int'(sel) == idx);
      wv  = (data < 2) ? 2 : int'(data);
      if (!rst_n) begin
        m_cnt[k] = 0; m_act[k] = def_div[idx]; m_pv[k] = 0;
        m_tick[k] = 0; m_sq[k] = 0;
      end else if (sclr) begin
        m_cnt[k] = 0; m_tick[k] = 0; m_sq[k] = 0;
        if (hit) m_act[k] = wv;
        else if (m_pv[k]) m_act[k] = m_pend[k];
        m_pv[k] = 0;
      end else if (en[idx]) begin
        wrap = (m_cnt[k] + 1 >= m_act[k]);
        nxt  = wrap ? 0 : m_cnt[k] + 1;
        m_tick[k] = wrap;
        m_sq[k]   = (nxt >= m_act[k] / 2);
        m_cnt[k]  = nxt;
        if (wrap) begin
          if (hit) begin m_act[k] = wv; m_pv[k] = 0; end
          else if (m_pv[k]) begin m_act[k] = m_pend[k]; m_pv[k] = 0; end
        end else if (hit) begin
          m_pend[k] = wv; m_pv[k] = 1;
        end
      end else begin
        m_tick[k] = 0;
        if (hit) begin m_act[k] = wv; m_pv[k] = 0; end
      end
    end
  endfunction

  task automatic handCheck(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL sb_empty: got no entry expected one");
      return;
    end
    e = sb_q.pop_front();
    if ({tick, square} !== {e.tick, e.sq}) begin
      failures++;
      $display("[TB] FAIL sb_main at %0t: got tick=%b sq=%b expected tick=%b sq=%b",
               $time, tick, square, e.tick, e.sq);
    end
    checks++;
    if ({tick3, square3} !== {e.tick3, e.sq3}) begin
      failures++;
      $display("[TB] FAIL sb_3ch at %0t: got tick=%b sq=%b expected tick=%b sq=%b",
               $time, tick3, square3, e.tick3, e.sq3);
    end
  endtask

  task automatic applyStimulus(input logic rst_n, input logic [3:0] en, input logic sclr,
                               input logic wr, input logic [1:0] sel, input logic [7:0] data);
    exp_t e;
    reset_n = rst_n; ch_enable = en; sync_clr = sclr;
    div_wr = wr; div_sel = sel; div_data = data;
    modelStep(rst_n, en, sclr, wr, sel, data);
    for (int k = 0; k < 4; k++) begin
      e.tick[k] = m_tick[k];
      e.sq[k]   = m_sq[k];
    end
    for (int k = 0; k < 3; k++) begin
      e.tick3[k] = m_tick[k+4];
      e.sq3[k]   = m_sq[k+4];
    end
    sb_q.push_back(e);
    @(posedge clock_in);
    #1;
    checkOutput();
  endtask

  task automatic runIdle(input int n, input logic [3:0] en);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, en, 1'b0, 1'b0, 2'd0, 8'd0);
  endtask

  vec_t vecs[12];

  initial begin
    logic held_sq;
    bit   found;

    // Edge n after reset release, all channels enabled, divisors 4/5/2/10.
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0100};
    vecs[1]  = '{4'b1111, 4'b0100, 4'b0011};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b0111};
    vecs[3]  = '{4'b1111, 4'b0101, 4'b0010};
    vecs[4]  = '{4'b1111, 4'b0010, 4'b1100};
    vecs[5]  = '{4'b1111, 4'b0100, 4'b1001};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b1111};
    vecs[7]  = '{4'b1111, 4'b0101, 4'b1010};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b1110};
    vecs[9]  = '{4'b1111, 4'b1110, 4'b0001};
    vecs[10] = '{4'b1111, 4'b0000, 4'b0101};
    vecs[11] = '{4'b1111, 4'b0101, 4'b0010};

    reset_n = 1'b0; ch_enable = 4'b0000; sync_clr = 1'b0;
    div_wr = 1'b0; div_sel = 2'd0; div_data = 8'd0;

    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 8'd0);
    handCheck("reset_tick", {4'b0, tick}, 8'd0);
    handCheck("reset_square", {4'b0, square}, 8'd0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].en, 1'b0, 1'b0, 2'd0, 8'd0);
      handCheck($sformatf("vec%0d_tick", i), {4'b0, tick}, {4'b0, vecs[i].exp_tick});
      handCheck($sformatf("vec%0d_sq", i), {4'b0, square}, {4'b0, vecs[i].exp_sq});
    end
    runIdle(28, 4'b1111);

    // Channel 0 gated: no tick, square frozen.
    runIdle(2, 4'b1111);
    held_sq = square[0];
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 4'b1110, 1'b0, 1'b0, 2'd0, 8'd0);
      handCheck("gated_tick0", {7'b0, tick[0]}, 8'd0);
      handCheck("gated_sq0", {7'b0, square[0]}, {7'b0, held_sq});
    end
    runIdle(10, 4'b1111);

    // Mid-period write goes pending; then a sub-2 write clamps to 2.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt[0] == 1) found = 1;
      else runIdle(1, 4'b1111);
    end
    if (!found) begin failures++; checks++; $display("[TB] FAIL find_mid0: got none expected cnt=1"); end
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, 8'd6);
    runIdle(20, 4'b1111);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, 8'd0);
    runIdle(12, 4'b1111);

    // Overwritten pending write on ch1, then sync_clr with ch2 pending.
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 2'd1, 8'd7);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 2'd1, 8'd3);
    runIdle(12, 4'b1111);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 2'd2, 8'd9);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 8'd0);
    handCheck("sclr_tick", {4'b0, tick}, 8'd0);
    handCheck("sclr_square", {4'b0, square}, 8'd0);
    runIdle(20, 4'b1111);

    // Reset with a pending write discards it and restores defaults.
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 2'd3, 8'd4);
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 8'd0);
    handCheck("rst2_tick", {4'b0, tick}, 8'd0);
    handCheck("rst2_square", {4'b0, square}, 8'd0);
    runIdle(25, 4'b1111);

    // Write on ch0 wrap edge: new period of 3 starts immediately.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt[0] + 1 >= m_act[0]) found = 1;
      else runIdle(1, 4'b1111);
    end
    if (!found) begin failures++; checks++; $display("[TB] FAIL find_wrap0: got none expected wrap"); end
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, 8'd3);
    handCheck("wrapwr_tick", {7'b0, tick[0]}, 8'd1);
    runIdle(1, 4'b1111);
    handCheck("wrapwr_p1", {7'b0, tick[0]}, 8'd0);
    runIdle(1, 4'b1111);
    handCheck("wrapwr_p2", {7'b0, tick[0]}, 8'd0);
    runIdle(1, 4'b1111);
    handCheck("wrapwr_p3", {7'b0, tick[0]}, 8'd1);

    // Selector 3 is out of range for the 3-channel instance.
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1, 2'd3, 8'd2);
    runIdle(10, 4'b1111);
    // Disabled write and write together with sync_clr.
    applyStimulus(1'b1, 4'b1011, 1'b0, 1'b1, 2'd2, 8'd1);
    runIdle(4, 4'b1011);
    runIdle(6, 4'b1111);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1, 2'd1, 8'd4);
    runIdle(10, 4'b1111);

    // Random mix of gating, writes, sync_clr and reset.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] en;
      for (int b = 0; b < 4; b++) en[b] = ($urandom % 8) != 0;
      applyStimulus(($urandom % 100) != 0, en, ($urandom % 40) == 0,
                    ($urandom % 6) == 0, 2'($urandom % 4), 8'($urandom_range(0, 12)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
